// File: rtl/mmc_request_merger_pkg.sv
//----------------------------------------------------------------------------
// Module   : mmc_merge_pkg
// Purpose  : Shared field widths, request layout and FSM encoding for the
//            main-memory-control request merger.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package mmc_merge_pkg;

  localparam int c_bank_w = 3;
  localparam int c_page_w = 12;
  localparam int c_line_w = 5;
  localparam int c_req_w  = 1 + c_bank_w + c_page_w + c_line_w;

  // Request layout, MSB first.
  typedef struct packed {
    logic                is_write;
    logic [c_bank_w-1:0] bank;
    logic [c_page_w-1:0] page;
    logic [c_line_w-1:0] line;
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mmc_request_merger_if.sv
//----------------------------------------------------------------------------
// Module   : mmc_request_merger_if
// Purpose  : Queue-side peek/pop port and sequencer-side burst command port.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface mmc_request_merger_if
  import mmc_merge_pkg::*;
#(
  parameter int BANK_W = c_bank_w,
  parameter int PAGE_W = c_page_w,
  parameter int LINE_W = c_line_w
) ();

  localparam int c_req_w = 1 + BANK_W + PAGE_W + LINE_W;

  logic               pipe_valid;
  logic [c_req_w-1:0] pipe_data;
  logic               pipe_peek_valid;
  logic [c_req_w-1:0] pipe_peek_data;
  logic               pipe_peek_twoIn_valid;
  logic [c_req_w-1:0] pipe_peek_twoIn_data;
  logic               pipe_read;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_is_write;
  logic [BANK_W-1:0]  cmd_bank;
  logic [PAGE_W-1:0]  cmd_page;
  logic [LINE_W-1:0]  cmd_line;
  logic [1:0]         cmd_len;
  logic [15:0]        merged_count;

  modport master (
    output pipe_valid, pipe_data, pipe_peek_valid, pipe_peek_data,
           pipe_peek_twoIn_valid, pipe_peek_twoIn_data, cmd_ready,
    input  pipe_read, cmd_valid, cmd_is_write, cmd_bank, cmd_page,
           cmd_line, cmd_len, merged_count
  );

  modport slave (
    input  pipe_valid, pipe_data, pipe_peek_valid, pipe_peek_data,
           pipe_peek_twoIn_valid, pipe_peek_twoIn_data, cmd_ready,
    output pipe_read, cmd_valid, cmd_is_write, cmd_bank, cmd_page,
           cmd_line, cmd_len, merged_count
  );

endinterface

`default_nettype wire

// File: rtl/mmc_request_merger_match.sv
//----------------------------------------------------------------------------
// Module   : mmc_req_match
// Purpose  : Tests whether a candidate request continues the head request
//            at a given line offset within the same type/bank/page.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module mmc_req_match
  import mmc_merge_pkg::*;
#(
  parameter int BANK_W = c_bank_w,
  parameter int PAGE_W = c_page_w,
  parameter int LINE_W = c_line_w
) (
  input  wire logic [1+BANK_W+PAGE_W+LINE_W-1:0] i_head,
  input  wire logic [1+BANK_W+PAGE_W+LINE_W-1:0] i_cand,
  input  wire logic [1:0]                        i_offset,
  output logic                                   o_match
);

  localparam int c_req_w = 1 + BANK_W + PAGE_W + LINE_W;

  logic [LINE_W:0] w_sum;
  logic            w_same_tag;

  // The extra sum bit catches a run that would cross the end of the page.
  assign w_sum      = {1'b0, i_head[LINE_W-1:0]} + (LINE_W+1)'(i_offset);
  assign w_same_tag = (i_head[c_req_w-1:LINE_W] == i_cand[c_req_w-1:LINE_W]);
  assign o_match    = w_same_tag & ~w_sum[LINE_W] &
                      (w_sum[LINE_W-1:0] == i_cand[LINE_W-1:0]);

endmodule

`default_nettype wire

// File: rtl/mmc_request_merger.sv
//----------------------------------------------------------------------------
// Module   : mmc_request_merger
// Purpose  : Merges up to three sequential same-page requests from the final
//            queue into one burst command and drains the merged entries.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module mmc_request_merger
  import mmc_merge_pkg::*;
#(
  parameter int BANK_W     = c_bank_w,
  parameter int PAGE_W     = c_page_w,
  parameter int LINE_W     = c_line_w,
  parameter int MERGE_WAIT = 4,
  parameter int MAX_BURST  = 3
) (
  input  wire logic           clk,
  input  wire logic           reset_poweron_n,
  mmc_request_merger_if.slave mmc
);

  localparam int                c_req_w    = 1 + BANK_W + PAGE_W + LINE_W;
  localparam int                c_wait_w   = (MERGE_WAIT < 1) ? 1 : $clog2(MERGE_WAIT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MERGE_WAIT);
  localparam logic [1:0]        c_max_len  = 2'(MAX_BURST);

  state_t              r_state, w_state_nxt;
  logic [c_wait_w-1:0] r_wait, w_wait_nxt;
  logic [1:0]          r_drain_cnt, w_drain_nxt;
  logic                w_load;
  logic                w_pipe_read;

  logic                r_cmd_valid;
  logic                r_cmd_is_write;
  logic [BANK_W-1:0]   r_cmd_bank;
  logic [PAGE_W-1:0]   r_cmd_page;
  logic [LINE_W-1:0]   r_cmd_line;
  logic [1:0]          r_cmd_len;
  logic [15:0]         r_merged;

  logic                w_m1_raw, w_m2_raw;
  logic                w_match1, w_match2;
  logic [1:0]          w_len_raw, w_len;
  logic                w_wait_done;
  logic                w_out_free;
  logic                w_decide;
  logic [16:0]         w_merged_sum;

  mmc_req_match #(.BANK_W(BANK_W), .PAGE_W(PAGE_W), .LINE_W(LINE_W)) u_match1 (
    .i_head   (mmc.pipe_data),
    .i_cand   (mmc.pipe_peek_data),
    .i_offset (2'd1),
    .o_match  (w_m1_raw)
  );

  mmc_req_match #(.BANK_W(BANK_W), .PAGE_W(PAGE_W), .LINE_W(LINE_W)) u_match2 (
    .i_head   (mmc.pipe_data),
    .i_cand   (mmc.pipe_peek_twoIn_data),
    .i_offset (2'd2),
    .o_match  (w_m2_raw)
  );

  assign w_match1    = mmc.pipe_peek_valid & w_m1_raw;
  assign w_match2    = w_match1 & mmc.pipe_peek_twoIn_valid & w_m2_raw;
  assign w_len_raw   = 2'd1 + {1'b0, w_match1} + {1'b0, w_match2};
  assign w_len       = (w_len_raw > c_max_len) ? c_max_len : w_len_raw;
  assign w_wait_done = (r_wait >= c_wait_max);
  assign w_out_free  = ~r_cmd_valid | mmc.cmd_ready;

  // Issue once the burst cannot grow: a visible entry breaks the run, the
  // limit is reached, or the wait for missing peek entries has expired.
  assign w_decide = mmc.pipe_valid & w_out_free &
                    ((mmc.pipe_peek_valid & ~w_match1) |
                     (w_match1 & mmc.pipe_peek_twoIn_valid) |
                     (w_match1 & ~mmc.pipe_peek_twoIn_valid & w_wait_done) |
                     (~mmc.pipe_peek_valid & w_wait_done) |
                     (w_len == c_max_len));

  assign w_merged_sum = {1'b0, r_merged} + 17'(w_len - 2'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_drain_nxt = r_drain_cnt;
    w_load      = 1'b0;
    w_pipe_read = 1'b0;
    case (r_state)
      IDLE, GATHER: begin
        if (!mmc.pipe_valid) begin
          w_state_nxt = IDLE;
          w_wait_nxt  = '0;
        end else if (w_decide) begin
          w_load      = 1'b1;
          w_drain_nxt = w_len;
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = GATHER;
          w_wait_nxt  = w_wait_done ? r_wait : r_wait + 1'b1;
        end
      end
      DRAIN: begin
        w_pipe_read = mmc.pipe_valid;
        if (mmc.pipe_valid) begin
          w_drain_nxt = r_drain_cnt - 2'd1;
          if (r_drain_cnt == 2'd1) begin
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      r_state        <= IDLE;
      r_wait         <= '0;
      r_drain_cnt    <= '0;
      r_cmd_valid    <= 1'b0;
      r_cmd_is_write <= 1'b0;
      r_cmd_bank     <= '0;
      r_cmd_page     <= '0;
      r_cmd_line     <= '0;
      r_cmd_len      <= '0;
      r_merged       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_load) begin
        r_cmd_valid    <= 1'b1;
        r_cmd_is_write <= mmc.pipe_data[c_req_w-1];
        r_cmd_bank     <= mmc.pipe_data[c_req_w-2 -: BANK_W];
        r_cmd_page     <= mmc.pipe_data[LINE_W +: PAGE_W];
        r_cmd_line     <= mmc.pipe_data[LINE_W-1:0];
        r_cmd_len      <= w_len;
        r_merged       <= w_merged_sum[16] ? 16'hFFFF : w_merged_sum[15:0];
      end else if (mmc.cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign mmc.pipe_read    = w_pipe_read;
  assign mmc.cmd_valid    = r_cmd_valid;
  assign mmc.cmd_is_write = r_cmd_is_write;
  assign mmc.cmd_bank     = r_cmd_bank;
  assign mmc.cmd_page     = r_cmd_page;
  assign mmc.cmd_line     = r_cmd_line;
  assign mmc.cmd_len      = r_cmd_len;
  assign mmc.merged_count = r_merged;

endmodule

`default_nettype wire

// File: tb/tb_mmc_request_merger.sv
//----------------------------------------------------------------------------
// Module   : tb_mmc_request_merger
// Purpose  : Directed vector bench for mmc_request_merger with a queue model.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_mmc_request_merger;
  import mmc_merge_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_poweron_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  req_t q[$];

  mmc_request_merger_if #(.BANK_W(c_bank_w), .PAGE_W(c_page_w), .LINE_W(c_line_w)) bus ();

  mmc_request_merger #(
    .BANK_W(c_bank_w), .PAGE_W(c_page_w), .LINE_W(c_line_w),
    .MERGE_WAIT(4), .MAX_BURST(3)
  ) dut (
    .clk             (clk),
    .reset_poweron_n (reset_poweron_n),
    .mmc             (bus)
  );

  typedef struct {
    req_t r0, r1, r2;
    int   n;
    int   e_cyc, e_len, e_line, e_wr, e_bank, e_page;
  } vec_t;

  vec_t vecs[10];

  function automatic req_t mk(logic w, int b, int p, int l);
    req_t r;
    r.is_write = w;
    r.bank     = c_bank_w'(b);
    r.page     = c_page_w'(p);
    r.line     = c_line_w'(l);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.pipe_valid            = (q.size() > 0);
    bus.pipe_data             = (q.size() > 0) ? q[0] : '0;
    bus.pipe_peek_valid       = (q.size() > 1);
    bus.pipe_peek_data        = (q.size() > 1) ? q[1] : '0;
    bus.pipe_peek_twoIn_valid = (q.size() > 2);
    bus.pipe_peek_twoIn_data  = (q.size() > 2) ? q[2] : '0;
  endtask

  // Queue pops on the edge where pipe_read was high, then re-presents.
  task automatic tick();
    logic pr;
    pr = bus.pipe_read;
    @(posedge clk);
    #1;
    if (pr === 1'b1 && q.size() > 0) q.delete(0);
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    reset_poweron_n = 1'b0;
    bus.cmd_ready   = 1'b1;
    q.delete();
    drive();
    tick();
    tick();
    reset_poweron_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, pops, bad;
    logic [1:0] c_len;
    logic [4:0] c_line;
    logic [15:0] c_merged;
    logic c_wr;
    logic [2:0] c_bank;
    logic [11:0] c_page;

    //            r0                r1                r2                n cyc len line wr bank page
    vecs[0] = '{mk(0,2,5,3),     mk(0,2,5,4),     mk(0,2,5,5),     3, 1, 3, 3,  0, 2, 5};
    vecs[1] = '{mk(0,2,5,3),     mk(1,2,5,4),     '0,              2, 1, 1, 3,  0, 2, 5};
    vecs[2] = '{mk(0,2,5,31),    mk(0,2,5,0),     '0,              2, 1, 1, 31, 0, 2, 5};
    vecs[3] = '{mk(0,2,5,3),     mk(0,2,5,4),     '0,              2, 5, 2, 3,  0, 2, 5};
    vecs[4] = '{mk(0,2,5,3),     mk(0,3,5,4),     '0,              2, 1, 1, 3,  0, 2, 5};
    vecs[5] = '{mk(1,1,7,10),    mk(1,1,7,11),    mk(1,1,7,12),    3, 1, 3, 10, 1, 1, 7};
    vecs[6] = '{mk(0,6,9,9),     '0,              '0,              1, 5, 1, 9,  0, 6, 9};
    vecs[7] = '{mk(0,4,4095,29), mk(0,4,4095,30), mk(0,4,4095,31), 3, 1, 3, 29, 0, 4, 4095};
    vecs[8] = '{mk(0,2,5,3),     mk(0,2,5,5),     mk(0,2,5,6),     3, 1, 1, 3,  0, 2, 5};
    vecs[9] = '{mk(0,2,5,3),     mk(0,2,6,4),     '0,              2, 1, 1, 3,  0, 2, 5};

    do_reset();
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_pipe_read", 32'(bus.pipe_read), 0);
    chk("rst_merged", 32'(bus.merged_count), 0);
    chk("rst_cmd_len", 32'(bus.cmd_len), 0);
    chk("rst_cmd_line", 32'(bus.cmd_line), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      q.push_back(vecs[i].r0);
      if (vecs[i].n > 1) q.push_back(vecs[i].r1);
      if (vecs[i].n > 2) q.push_back(vecs[i].r2);
      drive();
      first = -1; pops = 0;
      c_len = '0; c_line = '0; c_merged = '0; c_wr = 1'b0; c_bank = '0; c_page = '0;
      for (int k = 0; k < 20; k++) begin
        if (first < 0 && bus.cmd_valid === 1'b1) begin
          first    = cyc;
          c_len    = bus.cmd_len;
          c_line   = bus.cmd_line;
          c_wr     = bus.cmd_is_write;
          c_bank   = bus.cmd_bank;
          c_page   = bus.cmd_page;
          c_merged = bus.merged_count;
        end
        if (bus.pipe_read === 1'b1 && (first < 0 || cyc <= first + int'(c_len))) pops++;
        tick();
      end
      chk($sformatf("v%0d_cycle", i), 32'(first), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d_len", i), 32'(c_len), 32'(vecs[i].e_len));
      chk($sformatf("v%0d_line", i), 32'(c_line), 32'(vecs[i].e_line));
      chk($sformatf("v%0d_wr", i), 32'(c_wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_bank", i), 32'(c_bank), 32'(vecs[i].e_bank));
      chk($sformatf("v%0d_page", i), 32'(c_page), 32'(vecs[i].e_page));
      chk($sformatf("v%0d_pops", i), 32'(pops), 32'(vecs[i].e_len));
      chk($sformatf("v%0d_merged", i), 32'(c_merged), 32'(vecs[i].e_len - 1));
    end

    // Head alone; a late follower appears after the short burst has issued.
    do_reset();
    q.push_back(mk(0,2,5,3));
    drive();
    for (int k = 0; k < 14; k++) begin
      if (cyc == 4) chk("late_c4_valid", 32'(bus.cmd_valid), 0);
      if (cyc == 5) begin
        chk("late_c5_valid", 32'(bus.cmd_valid), 1);
        chk("late_c5_len", 32'(bus.cmd_len), 1);
        chk("late_c5_pop", 32'(bus.pipe_read), 1);
      end
      if (cyc == 10) chk("late_c10_valid", 32'(bus.cmd_valid), 0);
      if (cyc == 11) begin
        chk("late_c11_valid", 32'(bus.cmd_valid), 1);
        chk("late_c11_line", 32'(bus.cmd_line), 4);
        chk("late_c11_merged", 32'(bus.merged_count), 0);
      end
      tick();
      if (cyc == 6) begin
        q.push_back(mk(0,2,5,4));
        drive();
      end
    end

    // Type change ends the run; the write issues on its own later.
    do_reset();
    q.push_back(mk(0,2,5,3));
    q.push_back(mk(1,2,5,4));
    drive();
    for (int k = 0; k < 9; k++) begin
      if (cyc == 2) begin
        chk("sep_c2_valid", 32'(bus.cmd_valid), 0);
        chk("sep_c2_pop", 32'(bus.pipe_read), 0);
      end
      if (cyc == 7) begin
        chk("sep_c7_valid", 32'(bus.cmd_valid), 1);
        chk("sep_c7_wr", 32'(bus.cmd_is_write), 1);
        chk("sep_c7_line", 32'(bus.cmd_line), 4);
      end
      tick();
    end

    // Sequencer stalls: command holds, drain still completes.
    do_reset();
    bus.cmd_ready = 1'b0;
    q.push_back(mk(0,2,5,3));
    q.push_back(mk(0,2,5,4));
    q.push_back(mk(0,2,5,5));
    q.push_back(mk(0,2,5,10));
    drive();
    bad = 0; pops = 0;
    for (int k = 0; k < 14; k++) begin
      if (cyc >= 1 && cyc <= 11 &&
          (bus.cmd_valid !== 1'b1 || bus.cmd_line !== 5'd3 || bus.cmd_len !== 2'd3)) bad++;
      if (cyc <= 11 && bus.pipe_read === 1'b1) pops++;
      if (cyc == 12) begin
        chk("stall_c12_valid", 32'(bus.cmd_valid), 1);
        chk("stall_c12_line", 32'(bus.cmd_line), 10);
        chk("stall_c12_len", 32'(bus.cmd_len), 1);
        chk("stall_c12_merged", 32'(bus.merged_count), 2);
      end
      if (cyc == 13) chk("stall_c13_valid", 32'(bus.cmd_valid), 0);
      tick();
      if (cyc == 11) bus.cmd_ready = 1'b1;
    end
    chk("stall_hold_bad", 32'(bad), 0);
    chk("stall_pops", 32'(pops), 3);

    // Reset in the middle of a three-entry drain.
    do_reset();
    q.push_back(mk(0,2,5,3));
    q.push_back(mk(0,2,5,4));
    q.push_back(mk(0,2,5,5));
    drive();
    tick();
    tick();
    chk("rstmid_c2_pop", 32'(bus.pipe_read), 1);
    reset_poweron_n = 1'b0;
    tick();
    chk("rstmid_pipe_valid", 32'(bus.pipe_valid), 1);
    chk("rstmid_pop", 32'(bus.pipe_read), 0);
    chk("rstmid_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rstmid_merged", 32'(bus.merged_count), 0);
    chk("rstmid_cmd_len", 32'(bus.cmd_len), 0);
    reset_poweron_n = 1'b1;
    tick();
    chk("rstmid_after_pop", 32'(bus.pipe_read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
